// File: rtl/alu_pkg.sv
// Shared constants and types for the sequential ALU and its decoder.
package alu_pkg;

  // Internal operation codes (match the classic MIPS ALU control encoding)
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  // R-type funct field values
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_MULT = 6'd24;

  // Control FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/result handshake bundle between the register-read stage and the ALU unit.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [3:0]       op_code;

  // Requester / result consumer side
  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, op_code
  );

  // ALU unit side
  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, op_code
  );

endinterface

// File: rtl/alu_decode.sv
// Combinational alu_op/funct to internal operation code decoder.
module alu_decode
  import alu_pkg::*;
#(
  parameter bit MULT_EN = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] op_code
);

  // Decode the main control op, falling back to funct for R-type
  always_comb begin
    op_code = OP_AND;
    case (alu_op)
      2'd0: op_code = OP_ADD;
      2'd1: op_code = OP_SUB;
      2'd2: begin
        case (funct)
          F_ADD:   op_code = OP_ADD;
          F_SUB:   op_code = OP_SUB;
          F_AND:   op_code = OP_AND;
          F_OR:    op_code = OP_OR;
          F_NOR:   op_code = OP_NOR;
          F_SLT:   op_code = OP_SLT;
          // Without the multiplier, MULT behaves like any unknown funct
          F_MULT:  op_code = MULT_EN ? OP_MUL : OP_AND;
          default: op_code = OP_AND;
        endcase
      end
      default: op_code = OP_AND;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with registered result/flags and an iterative shift-add multiplier.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          MULT_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic [3:0]       op_code_q, op_code_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       dec_op;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] sum, diff, exec_res;
  logic             exec_ovf;
  logic [WIDTH-1:0] acc_step;

  assign op_a = bus.a;
  assign op_b = bus.b;

  alu_decode #(
    .MULT_EN (MULT_EN)
  ) u_decode (
    .alu_op  (bus.alu_op),
    .funct   (bus.funct),
    .op_code (dec_op)
  );

  // A held result may be replaced in the same cycle the consumer takes it
  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.op_code   = op_code_q;

  // Single-cycle execution of the non-multiply operations
  always_comb begin
    sum      = op_a + op_b;
    diff     = op_a - op_b;
    exec_res = op_a & op_b;
    exec_ovf = 1'b0;
    case (dec_op)
      OP_OR:  exec_res = op_a | op_b;
      OP_ADD: begin
        exec_res = sum;
        exec_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = diff;
        exec_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_NOR: exec_res = ~(op_a | op_b);
      default: exec_res = op_a & op_b;
    endcase
  end

  // One shift-add partial product per cycle
  assign acc_step = acc_q + (b_sh_q[0] ? a_sh_q : '0);

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    op_code_d  = op_code_q;
    acc_d      = acc_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    cnt_d      = cnt_q;

    case (state_q)
      StMult: begin
        acc_d  = acc_step;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CntW'(1);
        // Last step folds straight into the result so latency stays WIDTH+1
        if (cnt_q == LastStep) begin
          result_d   = acc_step;
          zero_d     = (acc_step == '0);
          overflow_d = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    // Acceptance only happens in IDLE or DONE, so it never collides with MULT
    if (accept) begin
      op_code_d = dec_op;
      if (dec_op == OP_MUL) begin
        state_d = StMult;
        acc_d   = '0;
        cnt_d   = '0;
        a_sh_d  = op_a;
        b_sh_d  = op_b;
      end else begin
        state_d    = StDone;
        result_d   = exec_res;
        zero_d     = (exec_res == '0);
        overflow_d = exec_ovf;
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      op_code_q  <= '0;
      acc_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      op_code_q  <= op_code_d;
      acc_q      <= acc_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised successor to the MIPS ALU control path. Decodes alu_op/funct into an internal operation code and executes the operation on WIDTH-bit operands.
- Adds a valid/ready handshake on both sides, a registered result with zero and overflow flags, and an optional iterative shift-add multiplier (MULT, low WIDTH bits).
- Sits between the register-file read stage and writeback in the multi-cycle MIPS datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 4..64).
- MULT_EN, 1, 1 = funct MULT executes iteratively; 0 = funct MULT decodes as the default operation (AND).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_op  in  2  0=ADD, 1=SUB, 2=decode funct, 3=AND
- funct  in  6  R-type function field (used when alu_op=2)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- op_code  out  4  decoded operation code of the held result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n clears all state immediately, independent of clk).
- Reset values: state=IDLE, result=0, zero=0, overflow=0, op_code=0, out_valid=0, in_ready=1 (combinational from state).
- Operation codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, MUL=3.
- funct decode (alu_op=2): 32→ADD, 34→SUB, 36→AND, 37→OR, 39→NOR, 42→SLT, 24→MUL (when MULT_EN=1). Any other funct→AND.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH.
  - overflow = signed overflow of a±b.
  - SLT is signed compare: result = {WIDTH-1 zeros, a<b}.
  - NOR = ~(a|b).
  - MUL = low WIDTH bits of a*b; unsigned and signed give the same low bits.
  - zero is computed from the final result.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch operands and decode. Non-MUL ops go to DONE with the result registered at that edge. MUL goes to MULT with acc=0 and cnt=0.
  - MULT: one shift-add step per cycle (if b_sh[0] then acc+=a_sh; a_sh<<=1; b_sh>>=1; cnt++). After WIDTH steps, load result=acc and go to DONE. in_ready=0 throughout.
  - DONE: out_valid=1 and result/flags/op_code held stable until out_ready. On out_ready: if in_valid is also high, accept the new request in the same cycle (in_ready=out_ready in DONE) and branch as from IDLE; otherwise go to IDLE.
- Latency:
  - Non-MUL: out_valid high in the cycle after the acceptance edge.
  - MUL: out_valid high WIDTH+1 cycles after the acceptance edge.
  - Throughput for back-to-back non-MUL ops with out_ready=1: one result per cycle.
- Boundary conditions:
  - Inputs are ignored when in_ready=0.
  - in_valid may drop without acceptance; no state change results.
  - out_valid stays high indefinitely under backpressure.
  - rst_n low during MULT or DONE aborts the operation immediately; the result is lost and out_valid=0.
  - A MUL with b=0 still takes WIDTH cycles.

Decomposition:
- Package alu_pkg holds:
  - op-code constants (OP_AND, OP_OR, OP_ADD, OP_MUL, OP_SUB, OP_SLT, OP_NOR);
  - funct constants (F_ADD=32, F_SUB=34, F_AND=36, F_OR=37, F_NOR=39, F_SLT=42, F_MULT=24);
  - FSM state enum.
- Sub-module alu_decode: a combinational alu_op/funct→op_code decoder, reused by the single-cycle datapath.

Test Plan:
- WIDTH=8. Reset, then alu_op=0, a=0x7F, b=0x01, in_valid=1 → next cycle out_valid=1, result=0x80, overflow=1, zero=0, op_code=2.
- alu_op=2, funct=42, a=0xFF, b=0x01 → result=0x01 (−1<1); then funct=34, a=5, b=5 → result=0, zero=1, op_code=6.
- alu_op=2, funct=24, a=13, b=11 → in_ready=0 for 8 cycles, out_valid on cycle 9 after acceptance, result=0x8F (143), op_code=3; with MULT_EN=0 → result=13&11=0x09, op_code=0.
- Backpressure: out_ready=0 for 5 cycles after the result → result/flags stable, in_ready=0. Assert out_ready with in_valid (OR, a=0xF0, b=0x0F) → next result 0xFF in the following cycle.
- Stream of 4 ADDs with in_valid=out_ready=1 → 4 consecutive out_valid cycles with correct sums.
- Assert rst_n=0 mid-MULT (cycle 4), asynchronously off-edge → out_valid=0, in_ready=1 immediately. After release, a fresh ADD of 2+3 → result 5.
- funct=63 with alu_op=2 → AND result, op_code=0.
